// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_chain register chain: depth limit,
// occupancy width helper and the per-stage update command.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    CMD_KEEP  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_FLUSH = 2'd2
  } stage_cmd_e;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Valid/ready/data beat channel; master drives the beat, slave drives ready.
interface pipe_stage_chain_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: valid bit plus payload with flush > hold > load priority.
// An invalid stage presents the default payload on o_data.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_hold,
  input  logic                  i_load,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_default,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t     r_stage;
  stage_cmd_e w_cmd;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_cmd = CMD_KEEP;
    if (i_flush) begin
      w_cmd = CMD_FLUSH;
    end else if (!i_hold && i_load) begin
      w_cmd = CMD_LOAD;
    end
  end

  // NOTE: reset loads a constant; the default payload is muxed on the output
  // instead, so an asynchronous reset never samples a live input bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      case (w_cmd)
        CMD_FLUSH: r_stage <= '{valid: 1'b0, data: i_default};
        CMD_LOAD:  r_stage <= '{valid: i_valid, data: (i_valid ? i_data : i_default)};
        default:   r_stage <= r_stage;
      endcase
    end
  end

  assign o_valid = r_stage.valid;
  assign o_data  = r_stage.valid ? r_stage.data : i_default;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised register chain with valid/ready handshake, global hold,
// per-stage flush and optional bubble collapse (elastic) or lockstep advance.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter bit COLLAPSE   = 1'b1
) (
  input  logic                          sys_clk,
  input  logic                          sys_arst,
  input  logic                          flag_hold,
  input  logic [DEPTH-1:0]              flush_mask,
  input  logic [DATA_WIDTH-1:0]         default_value,
  pipe_stage_chain_if.slave             in_if,
  pipe_stage_chain_if.master            out_if,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be 1..16");
  end

  logic [DEPTH-1:0]                 w_v;
  logic [DEPTH-1:0]                 w_vi;
  logic [DEPTH-1:0]                 w_rdy;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_src;
  logic                             w_in_fire;

  // Elastic: a stage may move if it is empty or everything downstream moves.
  // Lockstep: every stage follows the output stage.
  always_comb begin
    logic l_rdy;
    l_rdy = out_if.ready;
    w_rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (COLLAPSE) begin
        l_rdy = ~w_v[i] | l_rdy;
      end else begin
        l_rdy = ~w_v[DEPTH-1] | out_if.ready;
      end
      w_rdy[i] = l_rdy;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(w_v[i]);
    end
  end

  assign in_if.ready  = w_rdy[0] & ~flag_hold & ~flush_mask[0] & ~sys_arst;
  assign w_in_fire    = in_if.valid & in_if.ready;
  assign out_if.valid = w_v[DEPTH-1] & ~flag_hold & ~flush_mask[DEPTH-1];
  assign out_if.data  = w_d[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_vi[g]  = w_in_fire;
      assign w_src[g] = in_if.data;
    end else begin : g_body
      // A beat leaving a flushed stage is dropped rather than handed forward.
      assign w_vi[g]  = w_v[g-1] & ~flush_mask[g-1];
      assign w_src[g] = w_d[g-1];
    end

    pipe_stage_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk       (sys_clk),
      .rst       (sys_arst),
      .i_flush   (flush_mask[g]),
      .i_hold    (flag_hold),
      .i_load    (w_rdy[g]),
      .i_valid   (w_vi[g]),
      .i_data    (w_src[g]),
      .i_default (default_value),
      .o_valid   (w_v[g]),
      .o_data    (w_d[g])
    );
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: elastic and lockstep DEPTH=3 instances, a
// per-cycle vector table, hand-written corner sequences and scoreboards.
module tb_pipe_stage_chain;

  localparam int DW = 32;
  localparam logic [DW-1:0] DV = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] FV = 32'h0000_0013;

  logic          sys_clk;
  logic          sys_arst;
  logic          flag_hold;
  logic [2:0]    flush_mask;
  logic [DW-1:0] default_value;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic [1:0]    occ_e;
  logic [1:0]    occ_l;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_e_en = 1'b0;
  bit mon_l_en = 1'b0;
  logic [DW-1:0] q_e[$];
  logic [DW-1:0] q_l[$];

  pipe_stage_chain_if #(.DATA_WIDTH(DW)) up_e ();
  pipe_stage_chain_if #(.DATA_WIDTH(DW)) dn_e ();
  pipe_stage_chain_if #(.DATA_WIDTH(DW)) up_l ();
  pipe_stage_chain_if #(.DATA_WIDTH(DW)) dn_l ();

  assign up_e.valid = in_valid;
  assign up_e.data  = in_data;
  assign dn_e.ready = out_ready;
  assign up_l.valid = in_valid;
  assign up_l.data  = in_data;
  assign dn_l.ready = out_ready;

  pipe_stage_chain #(.DATA_WIDTH(DW), .DEPTH(3), .COLLAPSE(1'b1)) dut_e (
    .sys_clk       (sys_clk),
    .sys_arst      (sys_arst),
    .flag_hold     (flag_hold),
    .flush_mask    (flush_mask),
    .default_value (default_value),
    .in_if         (up_e),
    .out_if        (dn_e),
    .occupancy     (occ_e)
  );

  pipe_stage_chain #(.DATA_WIDTH(DW), .DEPTH(3), .COLLAPSE(1'b0)) dut_l (
    .sys_clk       (sys_clk),
    .sys_arst      (sys_arst),
    .flag_hold     (flag_hold),
    .flush_mask    (flush_mask),
    .default_value (default_value),
    .in_if         (up_l),
    .out_if        (dn_l),
    .occupancy     (occ_l)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboards: push on in_fire, pop and compare on out_fire.
  always @(negedge sys_clk) begin
    #2;
    if (mon_e_en && !sys_arst) begin
      if (in_valid && up_e.ready) q_e.push_back(in_data);
      if (dn_e.valid && out_ready) begin
        if (q_e.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_e: unexpected beat %h, expected none", dn_e.data);
        end else begin
          check("sb_e", dn_e.data, q_e.pop_front());
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    #2;
    if (mon_l_en && !sys_arst) begin
      if (in_valid && up_l.ready) q_l.push_back(in_data);
      if (dn_l.valid && out_ready) begin
        if (q_l.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_l: unexpected beat %h, expected none", dn_l.data);
        end else begin
          check("sb_l", dn_l.data, q_l.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] idata;
    logic          ordy;
    logic          hold;
    logic [2:0]    flush;
    logic [DW-1:0] dflt;
    logic          exp_ir;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic [1:0]    exp_occ;
    int            drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [DW-1:0] idata, logic ordy, logic hold,
                              logic [2:0] flush, logic [DW-1:0] dflt, logic exp_ir,
                              logic exp_ov, logic [DW-1:0] exp_od, logic [1:0] exp_occ,
                              int drop);
    vec_t v;
    v.iv = iv; v.idata = idata; v.ordy = ordy; v.hold = hold; v.flush = flush;
    v.dflt = dflt; v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_od = exp_od;
    v.exp_occ = exp_occ; v.drop = drop;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] idata, input logic ordy);
    @(negedge sys_clk);
    in_valid  = iv;
    in_data   = idata;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    sys_arst      = 1'b1;
    flag_hold     = 1'b0;
    flush_mask    = 3'b000;
    default_value = DV;
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b0;

    // Streaming, 3 beats back to back.
    vecs.push_back(mk(1, 32'h11, 1, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    vecs.push_back(mk(1, 32'h22, 1, 0, 3'b000, DV, 1, 0, DV,    2'd1, 0));
    vecs.push_back(mk(1, 32'h33, 1, 0, 3'b000, DV, 1, 0, DV,    2'd2, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h11, 2'd3, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h22, 2'd2, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h33, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    // Elastic backpressure: 4th beat waits, then drain with simultaneous in/out fire.
    vecs.push_back(mk(1, 32'h41, 0, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    vecs.push_back(mk(1, 32'h42, 0, 0, 3'b000, DV, 1, 0, DV,    2'd1, 0));
    vecs.push_back(mk(1, 32'h43, 0, 0, 3'b000, DV, 1, 0, DV,    2'd2, 0));
    vecs.push_back(mk(1, 32'h44, 0, 0, 3'b000, DV, 0, 1, 32'h41, 2'd3, 0));
    vecs.push_back(mk(1, 32'h44, 0, 0, 3'b000, DV, 0, 1, 32'h41, 2'd3, 0));
    vecs.push_back(mk(1, 32'h44, 1, 0, 3'b000, DV, 1, 1, 32'h41, 2'd3, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h42, 2'd3, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h43, 2'd2, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h44, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    // Hold for two cycles with the chain full.
    vecs.push_back(mk(1, 32'h61, 0, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    vecs.push_back(mk(1, 32'h62, 0, 0, 3'b000, DV, 1, 0, DV,    2'd1, 0));
    vecs.push_back(mk(1, 32'h63, 0, 0, 3'b000, DV, 1, 0, DV,    2'd2, 0));
    vecs.push_back(mk(1, 32'h64, 1, 1, 3'b000, DV, 0, 0, 32'h61, 2'd3, 0));
    vecs.push_back(mk(1, 32'h64, 1, 1, 3'b000, DV, 0, 0, 32'h61, 2'd3, 0));
    vecs.push_back(mk(1, 32'h64, 1, 0, 3'b000, DV, 1, 1, 32'h61, 2'd3, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h62, 2'd3, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h63, 2'd2, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 1, 32'h64, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    // Flush stages 0 and 1 (beats B, C) while A sits at the output.
    vecs.push_back(mk(1, 32'h0A, 0, 0, 3'b000, DV, 1, 0, DV,    2'd0, 0));
    vecs.push_back(mk(1, 32'h0B, 0, 0, 3'b000, DV, 1, 0, DV,    2'd1, 0));
    vecs.push_back(mk(1, 32'h0C, 0, 0, 3'b000, DV, 1, 0, DV,    2'd2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 3'b011, FV, 0, 1, 32'h0A, 2'd3, 2));
    vecs.push_back(mk(0, 32'h00, 0, 0, 3'b000, FV, 1, 1, 32'h0A, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, FV, 1, 1, 32'h0A, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, FV, 1, 0, FV,    2'd0, 0));
    // Flushed output stage with out_ready=1 must not fire.
    vecs.push_back(mk(1, 32'h77, 0, 0, 3'b000, FV, 1, 0, FV,    2'd0, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 3'b000, FV, 1, 0, FV,    2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 3'b000, FV, 1, 0, FV,    2'd1, 0));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b100, FV, 1, 0, 32'h77, 2'd1, 1));
    vecs.push_back(mk(0, 32'h00, 1, 0, 3'b000, FV, 1, 0, FV,    2'd0, 0));

    // Reset state, before the first clock edge.
    #1;
    check("rst.e.out_valid", dn_e.valid, 0);
    check("rst.e.in_ready",  up_e.ready, 0);
    check("rst.e.out_data",  dn_e.data,  DV);
    check("rst.e.occupancy", occ_e,      0);
    check("rst.l.out_valid", dn_l.valid, 0);
    check("rst.l.in_ready",  up_l.ready, 0);
    @(negedge sys_clk);
    sys_arst = 1'b0;
    mon_e_en = 1'b1;

    foreach (vecs[k]) begin
      @(negedge sys_clk);
      in_valid      = vecs[k].iv;
      in_data       = vecs[k].idata;
      out_ready     = vecs[k].ordy;
      flag_hold     = vecs[k].hold;
      flush_mask    = vecs[k].flush;
      default_value = vecs[k].dflt;
      #1;
      check($sformatf("row%0d.in_ready", k),  up_e.ready, vecs[k].exp_ir);
      check($sformatf("row%0d.out_valid", k), dn_e.valid, vecs[k].exp_ov);
      check($sformatf("row%0d.out_data", k),  dn_e.data,  vecs[k].exp_od);
      check($sformatf("row%0d.occupancy", k), occ_e,      vecs[k].exp_occ);
      for (int j = 0; j < vecs[k].drop; j++) void'(q_e.pop_back());
    end
    flush_mask    = 3'b000;
    flag_hold     = 1'b0;
    default_value = DV;

    // Reset mid-stream with two beats in flight.
    drive(1, 32'hE1, 0);
    drive(1, 32'hE2, 0);
    drive(0, 32'h00, 0);
    drive(0, 32'h00, 0);
    check("mid.pre.out_valid", dn_e.valid, 1);
    check("mid.pre.out_data",  dn_e.data,  32'hE1);
    check("mid.pre.occupancy", occ_e,      2);
    #1;
    sys_arst = 1'b1;
    #1;
    check("mid.rst.out_valid", dn_e.valid, 0);
    check("mid.rst.out_data",  dn_e.data,  DV);
    check("mid.rst.occupancy", occ_e,      0);
    check("mid.rst.in_ready",  up_e.ready, 0);
    q_e.delete();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_arst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(0, 32'h00, 1);
      check($sformatf("mid.post%0d.out_valid", c), dn_e.valid, 0);
    end
    drive(1, 32'hF1, 1);
    check("mid.new.in_ready", up_e.ready, 1);
    drive(0, 32'h00, 1);
    drive(0, 32'h00, 1);
    drive(0, 32'h00, 1);
    check("mid.new.out_valid", dn_e.valid, 1);
    check("mid.new.out_data",  dn_e.data,  32'hF1);
    drive(0, 32'h00, 1);
    mon_e_en = 1'b0;

    // Lockstep: stalled output with a bubble behind it must not collapse.
    sys_arst = 1'b1;
    @(negedge sys_clk);
    sys_arst = 1'b0;
    mon_l_en = 1'b1;
    drive(1, 32'hA1, 0);
    check("ls.a.in_ready", up_l.ready, 1);
    drive(0, 32'h00, 0);
    drive(1, 32'hB2, 0);
    check("ls.b.in_ready", up_l.ready, 1);
    drive(1, 32'hC3, 0);
    check("ls.stall0.in_ready",  up_l.ready, 0);
    check("ls.stall0.out_valid", dn_l.valid, 1);
    check("ls.stall0.out_data",  dn_l.data,  32'hA1);
    check("ls.stall0.occupancy", occ_l,      2);
    drive(1, 32'hC3, 0);
    check("ls.stall1.in_ready",  up_l.ready, 0);
    check("ls.stall1.occupancy", occ_l,      2);
    drive(1, 32'hC3, 1);
    check("ls.go.in_ready", up_l.ready, 1);
    drive(0, 32'h00, 1);
    check("ls.bubble.out_valid", dn_l.valid, 0);
    check("ls.bubble.occupancy", occ_l,      2);
    drive(0, 32'h00, 1);
    check("ls.b.out_data", dn_l.data, 32'hB2);
    drive(0, 32'h00, 1);
    check("ls.c.out_data", dn_l.data, 32'hC3);
    drive(0, 32'h00, 1);
    check("ls.end.occupancy", occ_l, 0);
    #3;
    mon_l_en = 1'b0;

    check("sb_e.leftover", q_e.size(), 0);
    check("sb_l.leftover", q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised multi-stage pipeline register chain with per-stage valid bits.
- Adds a valid/ready handshake, global hold, per-stage flush mask and optional bubble collapse.
- Sits between CPU pipeline phases (IF/ID/EX/MEM) or on a bus path where several registered stages need stall/kill control.
- An invalid stage always presents default_value, so bubbles read as NOPs downstream.

Parameters:
- DATA_WIDTH, 32, payload width per stage.
- DEPTH, 2, number of register stages, 1..16; stage 0 is the input side, stage DEPTH-1 drives out_data.
- COLLAPSE, 1: 1 = elastic mode, bubbles are squeezed out; 0 = lockstep mode, the whole chain advances together.

Ports:
- sys_clk  in  1  clock, all state on rising edge
- sys_arst  in  1  asynchronous reset, active-high
- flag_hold  in  1  global stall: freezes all stages
- flush_mask  in  DEPTH  bit i kills stage i
- default_value  in  DATA_WIDTH  payload loaded into invalid/flushed stages
- in_valid  in  1  upstream beat present
- in_data  in  DATA_WIDTH  upstream payload
- in_ready  out  1  chain accepts in_data this cycle
- out_valid  out  1  stage DEPTH-1 presents a beat
- out_data  out  DATA_WIDTH  stage DEPTH-1 payload
- out_ready  in  1  downstream accepts
- occupancy  out  $clog2(DEPTH+1)  count of valid stages (combinational popcount of v)

Behaviour:
- State: v[i] (1 bit) and d[i] (DATA_WIDTH) for i = 0..DEPTH-1.
- Reset (sys_arst=1, asynchronous): all v=0, all d=default_value. Outputs then read out_valid=0, in_ready=0 while reset is held, out_data=default_value, occupancy=0.
- Priority per stage: reset > flush > hold > advance/keep.
- Stage readiness, elastic mode (COLLAPSE=1):
  - rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - rdy[i] = ~v[i] | rdy[i+1].
- Stage readiness, lockstep mode (COLLAPSE=0):
  - rdy[i] = ~v[DEPTH-1] | out_ready for all i.
- out_valid = v[DEPTH-1] & ~flag_hold & ~flush_mask[DEPTH-1].
- in_ready = rdy[0] & ~flag_hold & ~flush_mask[0] & ~sys_arst.
- Fire events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Stage load, when rdy[i] & ~flag_hold:
  - Source is stage i-1, or in_data for i=0.
  - Incoming valid vi = v[i-1] & ~flush_mask[i-1] (for i=0: vi = in_fire).
  - v[i] <= vi; d[i] <= vi ? source data : default_value.
- If ~rdy[i] or flag_hold: stage i keeps v and d.
- Flush: flush_mask[i]=1 sets v[i]<=0, d[i]<=default_value next edge, even during flag_hold.
  - A beat leaving a flushed stage is dropped; it is never passed forward.
  - A flushed output stage never produces out_fire.
- Latency: an unstalled beat appears on out_data DEPTH cycles after in_fire. Throughput is 1 beat/cycle when out_ready=1.
- Elastic mode: a bubble ahead of a stalled output is filled, so in_ready stays high until all DEPTH stages are valid.
- Lockstep mode: with out_valid=1 and out_ready=0, no stage moves, including bubbles.
- Simultaneous events:
  - in_fire and out_fire in the same cycle: occupancy is unchanged.
  - Flush in the same cycle as hold: flush wins and hold applies to the other stages.
- Reset asserted mid-operation clears all in-flight beats immediately (asynchronous). No beat is emitted after reset release until a new in_fire.
- DEPTH=1: single register, in_ready = ~v[0] | out_ready, gated by hold, flush and reset as above.

Decomposition:
- Shared package pipe_pkg:
  - Constant PIPE_MAX_DEPTH = 16.
  - occupancy width function clog2(DEPTH+1).
  - Typedef stage_t {valid, data}.
- One natural sub-module: pipe_stage_cell. It is one v/d register with flush/hold/load priority and asynchronous reset, instantiated DEPTH times via generate. The ready chain and popcount stay in the top.

Test Plan:
- Streaming (DEPTH=3, COLLAPSE=1, out_ready=1): send 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on cycles 3, 4, 5. occupancy peaks at 3 and in_ready stays 1.
- Backpressure, elastic mode (DEPTH=3, COLLAPSE=1): out_ready=0, send 4 beats -> first 3 accepted, in_ready=0 on the 4th. Then out_ready=1 -> beats drain in order with no loss or duplication.
- Backpressure, lockstep mode (DEPTH=3, COLLAPSE=0): beat A at the output stalled, bubble in stage 1 -> stage 1 stays empty, in_ready=0 until out_fire.
- Hold: assert flag_hold for 2 cycles with 3 valid stages -> out_valid=0, in_ready=0, all d unchanged. After release, output order is preserved.
- Flush: valid 0xA/0xB/0xC in stages 2/1/0, flush_mask=3'b011, default_value=0x13 -> next cycle stages 0 and 1 are invalid with d=0x13, 0xA still delivered, occupancy=1.
- Reset mid-stream: assert sys_arst with 2 beats in flight -> out_valid=0 and out_data=default_value immediately, before any clock edge. After release, no stale beat emerges.
